// File: rtl/pcie_cpl_tlp_fifo.sv
// First-word fall-through FIFO for PCIe completion TLP beats with packet
// accounting and a one-cycle framing-error pulse on sop/eop sequence violations.
module pcie_cpl_tlp_fifo #(
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int TLP_SEG_COUNT  = 1,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [TLP_DATA_WIDTH-1:0] s_cpl_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0] s_cpl_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]  s_cpl_tlp_hdr,
  input  logic                      s_cpl_tlp_valid,
  input  logic                      s_cpl_tlp_sop,
  input  logic                      s_cpl_tlp_eop,
  output logic                      s_cpl_tlp_ready,

  output logic [TLP_DATA_WIDTH-1:0] m_cpl_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0] m_cpl_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]  m_cpl_tlp_hdr,
  output logic                      m_cpl_tlp_valid,
  output logic                      m_cpl_tlp_sop,
  output logic                      m_cpl_tlp_eop,
  input  logic                      m_cpl_tlp_ready,

  output logic [$clog2(DEPTH):0]    status_count,
  output logic [$clog2(DEPTH):0]    status_pkt_count,
  output logic                      status_framing_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (TLP_SEG_COUNT != 1) begin : g_bad_seg_count
    $error("pcie_cpl_tlp_fifo supports TLP_SEG_COUNT == 1 only");
  end

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_e;

  logic [TLP_DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [TLP_STRB_WIDTH-1:0] strb_mem [DEPTH];
  logic [TLP_HDR_WIDTH-1:0]  hdr_mem  [DEPTH];
  logic                      sop_mem  [DEPTH];
  logic                      eop_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   pkt_count;
  pkt_state_e    state;
  pkt_state_e    state_next;
  logic          framing_err_next;
  logic          framing_err_q;
  logic          push;
  logic          pop;

  // Handshakes depend only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle and there is no s-to-m combinational path.
  assign s_cpl_tlp_ready = ~rst & (count != FULL_COUNT);
  assign m_cpl_tlp_valid = ~rst & (count != '0);
  assign push            = s_cpl_tlp_valid & s_cpl_tlp_ready;
  assign pop             = m_cpl_tlp_valid & m_cpl_tlp_ready;

  assign m_cpl_tlp_data  = data_mem[rd_ptr];
  assign m_cpl_tlp_strb  = strb_mem[rd_ptr];
  assign m_cpl_tlp_hdr   = hdr_mem[rd_ptr];
  assign m_cpl_tlp_sop   = sop_mem[rd_ptr];
  assign m_cpl_tlp_eop   = eop_mem[rd_ptr];

  assign status_count         = count;
  assign status_pkt_count     = pkt_count;
  assign status_framing_error = framing_err_q;

  // NOTE: the storage array has no reset; occupancy is defined by the pointers
  // and count alone, and resetting wide RAM would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= s_cpl_tlp_data;
      strb_mem[wr_ptr] <= s_cpl_tlp_strb;
      hdr_mem[wr_ptr]  <= s_cpl_tlp_hdr;
      sop_mem[wr_ptr]  <= s_cpl_tlp_sop;
      eop_mem[wr_ptr]  <= s_cpl_tlp_eop;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pkt_count     <= '0;
      state         <= IDLE;
      framing_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({push & s_cpl_tlp_eop, pop & m_cpl_tlp_eop})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase

      state         <= state_next;
      framing_err_q <= framing_err_next;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_next       = state;
    framing_err_next = 1'b0;
    if (push) begin
      // A beat that breaks framing is still stored; its eop decides the state.
      framing_err_next = (state == IDLE) ? ~s_cpl_tlp_sop : s_cpl_tlp_sop;
      state_next       = s_cpl_tlp_eop ? IDLE : IN_PKT;
    end
  end

endmodule

// File: tb/tb_pcie_cpl_tlp_fifo.sv
// Self-checking bench for pcie_cpl_tlp_fifo: directed scenarios with random
// payloads, compared every cycle against a queue-based reference model.
module tb_pcie_cpl_tlp_fifo;

  localparam int DW    = 256;
  localparam int SW    = DW / 32;
  localparam int HW    = 128;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [HW-1:0] hdr;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_strb;
  logic [HW-1:0] s_hdr;
  logic          s_valid, s_sop, s_eop, s_ready;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_strb;
  logic [HW-1:0] m_hdr;
  logic          m_valid, m_sop, m_eop, m_ready;
  logic [CW-1:0] cnt, pkt_cnt;
  logic          ferr;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  bit    in_pkt  = 1'b0;
  bit    exp_ferr = 1'b0;

  pcie_cpl_tlp_fifo #(
    .TLP_DATA_WIDTH(DW), .TLP_STRB_WIDTH(SW), .TLP_HDR_WIDTH(HW),
    .TLP_SEG_COUNT(1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cpl_tlp_data(s_data), .s_cpl_tlp_strb(s_strb), .s_cpl_tlp_hdr(s_hdr),
    .s_cpl_tlp_valid(s_valid), .s_cpl_tlp_sop(s_sop), .s_cpl_tlp_eop(s_eop),
    .s_cpl_tlp_ready(s_ready),
    .m_cpl_tlp_data(m_data), .m_cpl_tlp_strb(m_strb), .m_cpl_tlp_hdr(m_hdr),
    .m_cpl_tlp_valid(m_valid), .m_cpl_tlp_sop(m_sop), .m_cpl_tlp_eop(m_eop),
    .m_cpl_tlp_ready(m_ready),
    .status_count(cnt), .status_pkt_count(pkt_cnt), .status_framing_error(ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].eop) n++;
    return n;
  endfunction

  task automatic rand_payload();
    s_data = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    s_strb = SW'($urandom());
    s_hdr  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // One clock: compare all outputs with the model, advance both across the edge.
  task automatic cycle(output bit pushed);
    bit    push, pop;
    beat_t b;
    #1;
    check("s_ready", s_ready, !rst && q.size() != DEPTH);
    check("m_valid", m_valid, !rst && q.size() != 0);
    if (!rst && q.size() != 0) begin
      check("m_data", m_data, q[0].data);
      check("m_strb", m_strb, q[0].strb);
      check("m_hdr",  m_hdr,  q[0].hdr);
      check("m_sop",  m_sop,  q[0].sop);
      check("m_eop",  m_eop,  q[0].eop);
    end
    check("count",     cnt,     q.size());
    check("pkt_count", pkt_cnt, model_pkts());
    check("framing",   ferr,    exp_ferr);
    push = !rst && s_valid && q.size() != DEPTH;
    pop  = !rst && m_ready && q.size() != 0;
    b = '{data: s_data, strb: s_strb, hdr: s_hdr, sop: s_sop, eop: s_eop};
    @(posedge clk);
    if (rst) begin
      q.delete();
      in_pkt   = 1'b0;
      exp_ferr = 1'b0;
    end else begin
      exp_ferr = push && (s_sop == in_pkt);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(b);
        in_pkt = !s_eop;
      end
    end
    pushed = push;
    #1;
  endtask

  task automatic beat(input bit v, input bit sop, input bit eop, input bit rdy,
                      output bit pushed);
    rand_payload();
    s_valid = v;
    s_sop   = sop;
    s_eop   = eop;
    m_ready = rdy;
    cycle(pushed);
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (q.size() != 0 && guard < 100) begin
      beat(1'b0, 1'($urandom()), 1'($urandom()), 1'b1, acc);
      guard++;
    end
    beat(1'b0, 1'b0, 1'b0, 1'b1, acc);
    check("drain_timeout", guard < 100, 1'b1);
  endtask

  initial begin
    bit acc;
    int guard;
    int max_pkt;

    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; m_ready = 1'b0;
    rand_payload();
    repeat (2) @(posedge clk);
    #1;
    cycle(acc);
    rst = 1'b0;

    // Single-beat TLP passes through with one cycle of latency.
    s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; m_ready = 1'b1;
    s_data = DW'(32'hDEADBEEF); s_strb = SW'(1); s_hdr = HW'(32'h4A000001);
    cycle(acc);
    s_valid = 1'b0;
    cycle(acc);
    cycle(acc);

    // Fill to full with the consumer stalled, offer a 17th beat, then pop one.
    for (int i = 0; i < DEPTH; i++) beat(1'b1, i == 0, i == DEPTH - 1, 1'b0, acc);
    beat(1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("full_rejects", acc, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b1, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b0, acc);
    drain();

    // Simultaneous push and pop at count 5 with eop on both sides.
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 1'b1, 1'b0, acc);
    beat(1'b1, 1'b1, 1'b1, 1'b1, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("simul_count", cnt, 5);
    drain();

    // Framing: repeated sop without eop, then a non-sop beat while idle.
    beat(1'b1, 1'b1, 1'b0, 1'b0, acc);
    beat(1'b1, 1'b1, 1'b0, 1'b0, acc);
    beat(1'b1, 1'b0, 1'b1, 1'b0, acc);
    beat(1'b1, 1'b0, 1'b1, 1'b0, acc);
    beat(1'b0, 1'b1, 1'b0, 1'b0, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("framing_stored", cnt, 4);
    drain();

    // Five eight-beat TLPs with random throttling; consumer lags at most one TLP.
    max_pkt = 0;
    for (int p = 0; p < 5; p++) begin
      guard = 0;
      while (model_pkts() > 1 && guard < 500) begin
        beat(1'b0, 1'($urandom()), 1'($urandom()), 1'($urandom()), acc);
        if (int'(pkt_cnt) > max_pkt) max_pkt = int'(pkt_cnt);
        guard++;
      end
      check("wrap_lag_timeout", guard < 500, 1'b1);
      for (int b = 0; b < 8; b++) begin
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 500) begin
          if ($urandom_range(0, 3) != 0)
            beat(1'b1, b == 0, b == 7, 1'($urandom()), acc);
          else
            beat(1'b0, 1'($urandom()), 1'($urandom()), 1'($urandom()), acc);
          if (int'(pkt_cnt) > max_pkt) max_pkt = int'(pkt_cnt);
          guard++;
        end
        check("wrap_push_timeout", guard < 500, 1'b1);
      end
    end
    check("wrap_max_pkt", max_pkt <= 2, 1'b1);
    drain();

    // Reset in the middle of a packet, then a clean two-beat TLP.
    for (int i = 0; i < 3; i++) beat(1'b1, i == 0, 1'b0, 1'b0, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b1, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b1, acc);
    rst = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 1'b1, acc);
    rst = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("post_reset_count", cnt, 0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, acc);
    beat(1'b1, 1'b0, 1'b1, 1'b0, acc);
    beat(1'b0, 1'b0, 1'b0, 1'b0, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_cpl_tlp_fifo.md
PCIE_CPL_TLP_FIFO -- requirements
Module: pcie_cpl_tlp_fifo

Interface
REQ-001 SHALL have parameter TLP_DATA_WIDTH, default 256, TLP payload width in bits.
REQ-002 SHALL have parameter TLP_STRB_WIDTH, default TLP_DATA_WIDTH/32, one strobe bit per dword.
REQ-003 SHALL have parameter TLP_HDR_WIDTH, default 128, TLP header width in bits.
REQ-004 SHALL have parameter TLP_SEG_COUNT, default 1; only value 1 is supported.
REQ-005 SHALL have parameter DEPTH, default 16, beat capacity; power of two, at least 2.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports s_cpl_tlp_data/strb/hdr  input  TLP_DATA_WIDTH/TLP_STRB_WIDTH/TLP_HDR_WIDTH  completion beat from the PCIe-to-AXI bridge.
REQ-009 SHALL have ports s_cpl_tlp_valid/sop/eop  input  1 each  beat qualifiers.
REQ-010 SHALL have port s_cpl_tlp_ready  output  1  accept indication.
REQ-011 SHALL have ports m_cpl_tlp_data/strb/hdr/valid/sop/eop  output  same widths  buffered beat to the consumer.
REQ-012 SHALL have port m_cpl_tlp_ready  input  1  consumer accept.
REQ-013 SHALL have port status_count  output  $clog2(DEPTH)+1  beats stored.
REQ-014 SHALL have port status_pkt_count  output  $clog2(DEPTH)+1  stored beats with eop=1.
REQ-015 SHALL have port status_framing_error  output  1  one-cycle pulse on a framing violation.

Function
REQ-016 SHALL push a beat when s_cpl_tlp_valid && s_cpl_tlp_ready, storing data, strb, hdr, sop and eop together.
REQ-017 SHALL pop a beat when m_cpl_tlp_valid && m_cpl_tlp_ready.
REQ-018 SHALL drive s_cpl_tlp_ready = (status_count != DEPTH) from registered state only; a same-cycle pop SHALL NOT enable a push when full.
REQ-019 SHALL drive m_cpl_tlp_valid = (status_count != 0) and present the oldest stored beat (first-word fall-through).
REQ-020 SHALL make a beat pushed in cycle N visible on m_cpl_* in cycle N+1 when the FIFO is empty; no combinational s-to-m path.
REQ-021 SHALL hold m_cpl_* outputs stable while m_cpl_tlp_valid=1 and m_cpl_tlp_ready=0.
REQ-022 SHALL update count: push only +1, pop only -1, push and pop together unchanged.
REQ-023 SHALL update status_pkt_count: +1 for a pushed eop beat, -1 for a popped eop beat, net 0 when both occur.
REQ-024 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0 with no special case.
REQ-025 SHALL track an in_packet state, IDLE or IN_PKT, updated only on accepted pushes.
REQ-026 SHALL transition IDLE->IN_PKT on sop=1, eop=0; IN_PKT->IDLE on eop=1; sop=1, eop=1 leaves it in IDLE.
REQ-027 SHALL pulse status_framing_error one cycle after an accepted push with sop=0 in IDLE, or sop=1 in IN_PKT.
REQ-028 SHALL store the offending beat unchanged on a framing error and take the state transition implied by that beat's eop.
REQ-029 SHALL ignore s_cpl_tlp_sop, eop, data, strb and hdr when s_cpl_tlp_valid=0.
REQ-030 SHALL treat beat contents as opaque; no modification of data, strb or hdr.

Reset
REQ-031 SHALL, while rst=1, set both pointers, status_count and status_pkt_count to 0, state to IDLE, and status_framing_error to 0.
REQ-032 SHALL drive s_cpl_tlp_ready=0 and m_cpl_tlp_valid=0 while rst=1.
REQ-033 SHALL discard all stored beats on reset, including a packet partly pushed or popped; the first cycle after reset SHALL show s_cpl_tlp_ready=1 and m_cpl_tlp_valid=0.
REQ-034 SHALL leave the storage array unreset; m_cpl_tlp_data/strb/hdr SHALL be don't-care while m_cpl_tlp_valid=0.

Verification
REQ-035 SHALL cover single-beat TLP: push sop=eop=1, hdr=0x4A000001, data=0xDEADBEEF, with m_ready=1 -> beat appears next cycle bit-exact, then count=0 and pkt_count=0.
REQ-036 SHALL cover fill to full: m_ready=0, push 16 beats -> s_ready=0 after the 16th; count=16; a 17th valid beat is not accepted; a pop then s_ready=1 the next cycle.
REQ-037 SHALL cover wrap: 40 beats across 5 eight-beat TLPs with random m_ready throttling -> output order and contents match input; pkt_count never exceeds 2 when consumption lags by at most one TLP.
REQ-038 SHALL cover simultaneous push and pop at count=5 -> count stays 5; eop beat in and out together -> pkt_count unchanged.
REQ-039 SHALL cover framing: sop=1 then sop=1 again without eop -> status_framing_error high for exactly 1 cycle; non-sop beat in IDLE -> pulse; both beats stored.
REQ-040 SHALL cover reset mid-packet: rst asserted after 3 of 8 beats pushed with 2 popped -> count=0, m_valid=0; a new 2-beat TLP after reset outputs correctly with no framing error.
